// File: rtl/vga_capture_receiver.sv
// VGA receive side: registers sync/RGB, recovers raster coordinates, qualifies lock
// against the expected line/frame periods and emits per-pixel capture strobes.
module vga_capture_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_BP     = 44,
  parameter int V_BP     = 30
) (
  input  logic       CLK25,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [9:0] in_r,
  input  logic [9:0] in_g,
  input  logic [9:0] in_b,
  output logic [9:0] cap_x,
  output logic [9:0] cap_y,
  output logic [9:0] cap_r,
  output logic [9:0] cap_g,
  output logic [9:0] cap_b,
  output logic       cap_valid,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines,
  output logic [7:0] err_count
);

  localparam logic [9:0] HB   = 10'(H_BP);
  localparam logic [9:0] HE   = 10'(H_BP + H_ACTIVE - 1);
  localparam logic [9:0] VB   = 10'(V_BP);
  localparam logic [9:0] VE   = 10'(V_BP + V_ACTIVE - 1);
  localparam logic [9:0] HT   = 10'(H_TOTAL);
  localparam logic [9:0] VT   = 10'(V_TOTAL);
  localparam logic [9:0] VT1  = 10'(V_TOTAL + 1);
  localparam logic [9:0] CMAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CMAX) ? v : v + 10'd1;
  endfunction

  logic       hs1_q, vs1_q, hsp_q, vsp_q;
  logic [9:0] r1_q, g1_q, b1_q;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] lp_q, lp_d, lc_q, lc_d, lc_inc;
  logic [9:0] line_len_q, frame_lines_q;
  state_t     state_q, state_d;
  logic       flag_q, flag_d, exempt_q, exempt_d;
  logic [7:0] err_q, err_d;
  logic       line_bad, loss;
  logic       hs_rise, hs_fall, vs_rise, vs_fall;
  logic       act, valid_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [9:0] cap_x_q, cap_y_q, cap_r_q, cap_g_q, cap_b_q;
  logic       valid_q, fs_q;

  assign hs_rise = hs1_q & ~hsp_q;
  assign hs_fall = ~hs1_q & hsp_q;
  assign vs_rise = vs1_q & ~vsp_q;
  assign vs_fall = ~vs1_q & vsp_q;

  // Counters describe the sample currently held in stage 1.
  always_comb begin
    hcnt_d = hs_rise ? 10'd0 : sat_inc(hcnt_q);
    vcnt_d = vcnt_q;
    if (vs_rise)      vcnt_d = 10'd0;
    else if (hs_fall) vcnt_d = sat_inc(vcnt_q);
    lp_d   = hs_fall ? 10'd1 : sat_inc(lp_q);
    lc_inc = hs_fall ? sat_inc(lc_q) : lc_q;
    lc_d   = lc_inc;
    // An hsync fall coincident with the vsync fall opens the new frame.
    if (vs_fall) lc_d = hs_fall ? 10'd1 : 10'd0;
  end

  always_comb begin
    state_d  = state_q;
    flag_d   = flag_q;
    exempt_d = exempt_q;
    err_d    = err_q;
    line_bad = 1'b0;
    loss     = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d  = MEASURE;
          flag_d   = 1'b0;
          exempt_d = 1'b1;
        end
      end
      MEASURE: begin
        line_bad = hs_fall & ~exempt_q & (lp_q != HT);
        if (hs_fall) exempt_d = 1'b0;
        if (vs_fall) begin
          if (!flag_q && !line_bad && lc_q == VT) state_d = LOCKED;
          flag_d = 1'b0;
        end else if (line_bad) begin
          flag_d = 1'b1;
        end
      end
      LOCKED: begin
        loss = (hs_fall & (lp_q != HT)) |
               (vs_fall & (lc_q != VT)) |
               (hs_fall & ~vs_fall & (lc_inc == VT1));
        if (loss) begin
          state_d = SEARCH;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_comb begin
    act     = (hcnt_d >= HB) && (hcnt_d <= HE) && (vcnt_d >= VB) && (vcnt_d <= VE);
    valid_d = (state_d == LOCKED) && act;
    x_d     = hcnt_d - HB;
    y_d     = vcnt_d - VB;
    fs_d    = valid_d && (x_d == 10'd0) && (y_d == 10'd0);
  end

  // Sync samples reset to the idle (high) level so release does not fake an edge.
  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      hsp_q <= 1'b1;
      vsp_q <= 1'b1;
      r1_q  <= '0;
      g1_q  <= '0;
      b1_q  <= '0;
    end else begin
      hs1_q <= hsync_in;
      vs1_q <= vsync_in;
      hsp_q <= hs1_q;
      vsp_q <= vs1_q;
      r1_q  <= in_r;
      g1_q  <= in_g;
      b1_q  <= in_b;
    end
  end

  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      lp_q          <= '0;
      lc_q          <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      lp_q   <= lp_d;
      lc_q   <= lc_d;
      if (hs_fall) line_len_q <= lp_q;
      if (vs_fall) frame_lines_q <= lc_q;
    end
  end

  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      state_q  <= SEARCH;
      flag_q   <= 1'b0;
      exempt_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      exempt_q <= exempt_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge CLK25 or posedge reset) begin
    if (reset) begin
      cap_x_q <= '0;
      cap_y_q <= '0;
      cap_r_q <= '0;
      cap_g_q <= '0;
      cap_b_q <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      fs_q    <= fs_d;
      if (valid_d) begin
        cap_x_q <= x_d;
        cap_y_q <= y_d;
        cap_r_q <= r1_q;
        cap_g_q <= g1_q;
        cap_b_q <= b1_q;
      end
    end
  end

  assign cap_x       = cap_x_q;
  assign cap_y       = cap_y_q;
  assign cap_r       = cap_r_q;
  assign cap_g       = cap_g_q;
  assign cap_b       = cap_b_q;
  assign cap_valid   = valid_q;
  assign frame_start = fs_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_q;

endmodule
